// File: rtl/fsqrt_issue_ctrl.sv
// Flow-control wrapper around a fixed-latency, non-stallable sqrt pipe: credit-gated issue,
// valid/tag shadow pipeline, and a first-word-fall-through result FIFO. Optional macro: FSQRT_SPECIAL_EN.
module fsqrt_issue_ctrl #(
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      pipe_x,
  input  logic [31:0]      pipe_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and a pop's freed credit appears one cycle later.
  logic fire;
  logic capture;
  logic pop;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [TAG_W-1:0]   tag_d [LATENCY];

  logic [31:0]        mem_res_q [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [31:0]        cap_res;

  assign pipe_x    = in_x;
  assign in_ready  = ~rst & (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W);
  assign fire      = in_valid & in_ready;
  assign capture   = vld_q[LATENCY-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign busy      = (inflight_q != '0) | (count_q != '0);
  assign out_res   = out_valid ? mem_res_q[rd_ptr_q] : '0;
  assign out_tag   = out_valid ? mem_tag_q[rd_ptr_q] : '0;

`ifdef FSQRT_SPECIAL_EN
  typedef enum logic [1:0] {
    CLS_PASS = 2'd0,
    CLS_NEGZ = 2'd1,
    CLS_QNAN = 2'd2,
    CLS_PINF = 2'd3
  } cls_e;

  cls_e cls_in;
  cls_e cls_q [LATENCY];
  cls_e cls_d [LATENCY];

  // NaN wins over sign; among signed values only -0 survives, everything else negative is invalid.
  always_comb begin
    cls_in = CLS_PASS;
    if (in_x[30:23] == 8'hFF && in_x[22:0] != '0) begin
      cls_in = CLS_QNAN;
    end else if (in_x[31]) begin
      cls_in = (in_x[30:0] == '0) ? CLS_NEGZ : CLS_QNAN;
    end else if (in_x[30:0] == 31'h7F80_0000) begin
      cls_in = CLS_PINF;
    end
  end

  always_comb begin
    cls_d[0] = cls_in;
    for (int i = 1; i < LATENCY; i++) begin
      cls_d[i] = cls_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    cls_q <= cls_d;
  end

  always_comb begin
    cap_res = pipe_res;
    unique case (cls_q[LATENCY-1])
      CLS_NEGZ: cap_res = 32'h8000_0000;
      CLS_QNAN: cap_res = 32'h7FC0_0000;
      CLS_PINF: cap_res = 32'h7F80_0000;
      default:  cap_res = pipe_res;
    endcase
  end
`else
  assign cap_res = pipe_res;
`endif

  always_comb begin
    vld_d[0] = fire;
    tag_d[0] = in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    tag_q <= tag_d;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    if (capture) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({capture, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    unique case ({fire, capture})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_res_q[wr_ptr_q] <= cap_res;
      mem_tag_q[wr_ptr_q] <= tag_q[LATENCY-1];
    end
  end

  // The credit check on issue must make a capture into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    capture |-> (count_q != DEPTH_C));

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Bench for fsqrt_issue_ctrl: behavioural sqrt-pipe stand-in, queue-based reference model,
// table-driven single ops, hand sequences for corner cases, then randomized traffic.
module tb_fsqrt_issue_ctrl;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
  localparam int TW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_x;
  logic [TW-1:0] in_tag;
  logic [31:0]   pipe_x;
  logic [31:0]   pipe_res;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_res;
  logic [TW-1:0] out_tag;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int pop_cnt = 0;

  logic [32+TW-1:0] exp_q[$];
  int               rdy_q[$];

  fsqrt_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_tag(in_tag), .pipe_x(pipe_x), .pipe_res(pipe_res), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- sqrt pipe stand-in ----------------
  function automatic logic [31:0] pipe_fn(input logic [31:0] x);
    if (x == 32'h4080_0000) return 32'h4000_0000;
    return {x[15:0], x[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  logic [31:0] pstage [LAT];
  always @(posedge clk) begin
    pstage[0] <= pipe_x;
    for (int i = 1; i < LAT; i++) pstage[i] <= pstage[i-1];
  end
  assign pipe_res = pipe_fn(pstage[LAT-1]);

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_of(input logic [31:0] x);
`ifdef FSQRT_SPECIAL_EN
    logic       s = x[31];
    logic [7:0] e = x[30:23];
    logic [22:0] m = x[22:0];
    if (e == 8'hFF && m != 0) return 32'h7FC0_0000;
    if (s && e == 0 && m == 0) return 32'h8000_0000;
    if (s) return 32'h7FC0_0000;
    if (e == 8'hFF) return 32'h7F80_0000;
`endif
    return pipe_fn(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- scoreboard / monitor (mid-cycle) ----------------
  always @(negedge clk) begin
    logic ev;
    if (rst) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      exp_q.delete();
      rdy_q.delete();
    end else begin
      ev = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (out_valid && ev) begin
        chk("out_res", out_res, exp_q[0][32+TW-1:TW]);
        chk("out_tag", 32'(out_tag), 32'(exp_q[0][TW-1:0]));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({exp_of(in_x), in_tag});
        rdy_q.push_back(cyc + LAT + 1);
      end
      if (out_valid && out_ready && ev) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
        pop_cnt++;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] x, input logic [TW-1:0] tag);
    step();
    in_valid = 1'b1;
    in_x     = x;
    in_tag   = tag;
  endtask

  function automatic logic [31:0] pick_x();
    case ($urandom_range(0, 9))
      0: return 32'h8000_0000;
      1: return 32'hBF80_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h7FC0_0001;
      5: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [31:0]   x;
    logic [TW-1:0] tag;
    logic [31:0]   res;
  } vec_t;
  vec_t vecs[5];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int acc;
    int pc0;
    bit stop;
    in_valid  = 1'b0;
    in_x      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_res", out_res, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    vecs[0] = '{32'h4080_0000, 6'd5, 32'h4000_0000};
`ifdef FSQRT_SPECIAL_EN
    vecs[1] = '{32'hBF80_0000, 6'd9, 32'h7FC0_0000};
    vecs[2] = '{32'h8000_0000, 6'd10, 32'h8000_0000};
    vecs[3] = '{32'h7F80_0000, 6'd11, 32'h7F80_0000};
`else
    vecs[1] = '{32'hBF80_0000, 6'd9, pipe_fn(32'hBF80_0000)};
    vecs[2] = '{32'h8000_0000, 6'd10, pipe_fn(32'h8000_0000)};
    vecs[3] = '{32'h7F80_0000, 6'd11, pipe_fn(32'h7F80_0000)};
`endif
    vecs[4] = '{32'h3F80_0000, 6'd12, pipe_fn(32'h3F80_0000)};

    // Single ops: latency counted from the accepting cycle, plus value check.
    for (int v = 0; v < 5; v++) begin
      drive_op(vecs[v].x, vecs[v].tag);
      @(negedge clk);
      chk("single_accept", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("single_latency", 32'(n), 32'(LAT + 1));
      chk("single_res", out_res, vecs[v].res);
      chk("single_tag", 32'(out_tag), 32'(vecs[v].tag));
      repeat (2) step();
    end

    // Back-to-back issue with continuous drain.
    pc0 = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      drive_op($urandom, TW'(i));
      @(negedge clk);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    step();
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    @(negedge clk);
    chk("b2b_throughput", 32'(pop_cnt - pc0), 32'd20);

    // Fill with the consumer stalled: credits run out after DEPTH accepts.
    step();
    out_ready = 1'b0;
    acc  = 0;
    stop = 0;
    for (int c = 0; c < 30 && !stop; c++) begin
      drive_op($urandom, TW'(c));
      @(negedge clk);
      if (in_ready) acc++;
      else stop = 1;
    end
    chk("fill_accepts", 32'(acc), 32'(DEPTH));
    step();
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    pc0 = pop_cnt;
    out_ready = 1'b1;
    @(negedge clk);
    chk("credit_not_combinational", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("credit_next_cycle", 32'(in_ready), 32'd1);
    repeat (10) step();
    chk("fill_drained", 32'(pop_cnt - pc0), 32'(DEPTH));

    // Reset with 3 ops in flight and 2 buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_op($urandom, TW'(20 + i));
    step();
    in_valid = 1'b0;
    repeat (LAT + 2 - 5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 2 * LAT; i++) begin
      step();
      @(negedge clk);
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Capture and pop in the same cycle with four entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_op($urandom, TW'(40 + i));
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("simul_head_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("simul_remaining", 32'(out_valid), 32'd1);
    end
    step();
    @(negedge clk);
    chk("simul_empty", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step();
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = pick_x();
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + DEPTH + 4) step();
    @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
